// File: rtl/memory_access_responder_if.sv
// Request/response and byte-RAM signals of the memory-access responder.
// The slave modport is the responder view; master is the requester plus RAM view.
interface memory_access_responder_if;
  logic        memory_access_load_byte;
  logic        memory_access_load_halfword;
  logic        memory_access_store_byte;
  logic        memory_access_store_halfword;
  logic [15:0] target_address;
  logic [15:0] target_data;
  logic [15:0] memory_data;
  logic        reset_memory_access;
  logic        busy;
  logic        access_error;
  logic [15:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [7:0]  ram_write_data;
  logic [7:0]  ram_read_data;
  logic        ram_ready;

  modport slave (
    input  memory_access_load_byte, memory_access_load_halfword,
    input  memory_access_store_byte, memory_access_store_halfword,
    input  target_address, target_data, ram_read_data, ram_ready,
    output memory_data, reset_memory_access, busy, access_error,
    output ram_address, ram_read, ram_write, ram_write_data
  );

  modport master (
    output memory_access_load_byte, memory_access_load_halfword,
    output memory_access_store_byte, memory_access_store_halfword,
    output target_address, target_data, ram_read_data, ram_ready,
    input  memory_data, reset_memory_access, busy, access_error,
    input  ram_address, ram_read, ram_write, ram_write_data
  );
endinterface

// File: rtl/memory_access_responder.sv
// Services level-held byte/halfword load/store requests over a byte-wide RAM port
// with wait states and a per-beat timeout; retires each request with a one-cycle pulse.
module memory_access_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                        clock,
  input logic                        reset,
  memory_access_responder_if.slave   mem_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT0 = 2'd1;
  localparam logic [1:0] BEAT1 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        is_half_q, is_half_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  b0_q, b0_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        retire_q, retire_d;
  logic        err_q, err_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_rd_q, ram_rd_d;
  logic        ram_wr_q, ram_wr_d;
  logic [7:0]  ram_wdat_q, ram_wdat_d;

  logic lb, lh, sb, sh;
  logic any_req, multi_req, req_load;

  assign lb = mem_if.memory_access_load_byte;
  assign lh = mem_if.memory_access_load_halfword;
  assign sb = mem_if.memory_access_store_byte;
  assign sh = mem_if.memory_access_store_halfword;

  assign any_req   = lb | lh | sb | sh;
  assign multi_req = (lb & (lh | sb | sh)) | (lh & (sb | sh)) | (sb & sh);
  assign req_load  = lb | lh;

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    is_half_d  = is_half_q;
    addr_d     = addr_q;
    data_d     = data_q;
    b0_d       = b0_q;
    wait_d     = wait_q;
    mem_data_d = mem_data_q;
    retire_d   = 1'b0;
    err_d      = err_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = ram_rd_q;
    ram_wr_d   = ram_wr_q;
    ram_wdat_d = ram_wdat_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          // Priority: load_byte > load_halfword > store_byte > store_halfword.
          is_load_d  = req_load;
          is_half_d  = !lb && (lh || !sb);
          addr_d     = mem_if.target_address;
          data_d     = mem_if.target_data;
          err_d      = err_q | multi_req;
          wait_d     = 16'd0;
          ram_addr_d = mem_if.target_address;
          ram_rd_d   = req_load;
          ram_wr_d   = !req_load;
          ram_wdat_d = mem_if.target_data[7:0];
          state_d    = BEAT0;
        end
      end

      BEAT0, BEAT1: begin
        if (mem_if.ram_ready) begin
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          if (state_q == BEAT0) begin
            if (is_load_q) b0_d = mem_if.ram_read_data;
            if (is_half_q) begin
              wait_d     = 16'd0;
              ram_addr_d = addr_q + 16'd1;
              ram_rd_d   = is_load_q;
              ram_wr_d   = !is_load_q;
              ram_wdat_d = data_q[15:8];
              state_d    = BEAT1;
            end else begin
              if (is_load_q) mem_data_d = {8'h00, mem_if.ram_read_data};
              retire_d = 1'b1;
              state_d  = DONE;
            end
          end else begin
            if (is_load_q) mem_data_d = {mem_if.ram_read_data, b0_q};
            retire_d = 1'b1;
            state_d  = DONE;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Abandon the access; the requester still gets its retire pulse.
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          err_d    = 1'b1;
          retire_d = 1'b1;
          state_d  = DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      is_half_q  <= 1'b0;
      addr_q     <= 16'd0;
      data_q     <= 16'd0;
      b0_q       <= 8'd0;
      wait_q     <= 16'd0;
      mem_data_q <= 16'd0;
      retire_q   <= 1'b0;
      err_q      <= 1'b0;
      ram_addr_q <= 16'd0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_wdat_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      is_half_q  <= is_half_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      b0_q       <= b0_d;
      wait_q     <= wait_d;
      mem_data_q <= mem_data_d;
      retire_q   <= retire_d;
      err_q      <= err_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      ram_wdat_q <= ram_wdat_d;
    end
  end

  assign mem_if.memory_data         = mem_data_q;
  assign mem_if.reset_memory_access = retire_q;
  assign mem_if.busy                = (state_q != IDLE);
  assign mem_if.access_error        = err_q;
  assign mem_if.ram_address         = ram_addr_q;
  assign mem_if.ram_read            = ram_rd_q;
  assign mem_if.ram_write           = ram_wr_q;
  assign mem_if.ram_write_data      = ram_wdat_q;

endmodule

// File: tb/tb_memory_access_responder.sv
// Directed bench for memory_access_responder with TIMEOUT=4; every expectation hand-computed.
module tb_memory_access_responder;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   wr_cycles;
  int   retire_at;

  memory_access_responder_if bus ();

  memory_access_responder #(.TIMEOUT(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .mem_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic lb, input logic lh, input logic sb, input logic sh);
    bus.memory_access_load_byte      = lb;
    bus.memory_access_load_halfword  = lh;
    bus.memory_access_store_byte     = sb;
    bus.memory_access_store_halfword = sh;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [15:0] mdata);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_retire"}, 32'(bus.reset_memory_access), 32'd0);
    check({tag, "_rd"},     32'(bus.ram_read), 32'd0);
    check({tag, "_wr"},     32'(bus.ram_write), 32'd0);
    check({tag, "_mdata"},  32'(bus.memory_data), 32'(mdata));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    bus.target_address = 16'h0000;
    bus.target_data    = 16'h0000;
    bus.ram_read_data  = 8'h00;
    bus.ram_ready      = 1'b1;

    // Reset: two cycles, then everything must read zero.
    tick();
    tick();
    reset = 1'b0;
    check_idle_outputs("rst", 16'h0000);
    check("rst_err",   32'(bus.access_error), 32'd0);
    check("rst_addr",  32'(bus.ram_address), 32'd0);
    check("rst_wdata", 32'(bus.ram_write_data), 32'd0);
    tick();
    check_idle_outputs("rst_after", 16'h0000);

    // Byte load, zero-extended.
    set_flags(1'b1, 1'b0, 1'b0, 1'b0);
    bus.target_address = 16'h1234;
    bus.ram_read_data  = 8'hAB;
    bus.ram_ready      = 1'b1;
    tick();
    check("lb_rd",     32'(bus.ram_read), 32'd1);
    check("lb_wr",     32'(bus.ram_write), 32'd0);
    check("lb_addr",   32'(bus.ram_address), 32'h1234);
    check("lb_busy",   32'(bus.busy), 32'd1);
    check("lb_noret",  32'(bus.reset_memory_access), 32'd0);
    tick();
    check("lb_retire", 32'(bus.reset_memory_access), 32'd1);
    check("lb_rd_off", 32'(bus.ram_read), 32'd0);
    check("lb_mdata",  32'(bus.memory_data), 32'h00AB);
    check("lb_busy2",  32'(bus.busy), 32'd1);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("lb_end", 16'h00AB);
    tick();
    check_idle_outputs("lb_noreserve", 16'h00AB);

    // Halfword load across the 0xFFFF wrap, two wait cycles on the first beat.
    set_flags(1'b0, 1'b1, 1'b0, 1'b0);
    bus.target_address = 16'hFFFF;
    bus.ram_ready      = 1'b0;
    bus.ram_read_data  = 8'h00;
    tick();
    check("lh_w1_rd",   32'(bus.ram_read), 32'd1);
    check("lh_w1_addr", 32'(bus.ram_address), 32'hFFFF);
    tick();
    check("lh_w2_rd",   32'(bus.ram_read), 32'd1);
    check("lh_w2_addr", 32'(bus.ram_address), 32'hFFFF);
    tick();
    check("lh_b0_rd",   32'(bus.ram_read), 32'd1);
    check("lh_b0_addr", 32'(bus.ram_address), 32'hFFFF);
    bus.ram_ready     = 1'b1;
    bus.ram_read_data = 8'h34;
    tick();
    check("lh_b1_rd",   32'(bus.ram_read), 32'd1);
    check("lh_b1_addr", 32'(bus.ram_address), 32'h0000);
    check("lh_b1_noret", 32'(bus.reset_memory_access), 32'd0);
    bus.ram_read_data = 8'h12;
    tick();
    check("lh_retire",  32'(bus.reset_memory_access), 32'd1);
    check("lh_mdata",   32'(bus.memory_data), 32'h1234);
    check("lh_rd_off",  32'(bus.ram_read), 32'd0);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("lh_end", 16'h1234);

    // Halfword store, little-endian byte order.
    set_flags(1'b0, 1'b0, 1'b0, 1'b1);
    bus.target_address = 16'h0100;
    bus.target_data    = 16'hBEEF;
    bus.ram_read_data  = 8'hCC;
    tick();
    check("sh_b0_wr",    32'(bus.ram_write), 32'd1);
    check("sh_b0_rd",    32'(bus.ram_read), 32'd0);
    check("sh_b0_addr",  32'(bus.ram_address), 32'h0100);
    check("sh_b0_wdata", 32'(bus.ram_write_data), 32'hEF);
    tick();
    check("sh_b1_wr",    32'(bus.ram_write), 32'd1);
    check("sh_b1_addr",  32'(bus.ram_address), 32'h0101);
    check("sh_b1_wdata", 32'(bus.ram_write_data), 32'hBE);
    tick();
    check("sh_retire",   32'(bus.reset_memory_access), 32'd1);
    check("sh_wr_off",   32'(bus.ram_write), 32'd0);
    check("sh_mdata",    32'(bus.memory_data), 32'h1234);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("sh_end", 16'h1234);
    tick();
    check_idle_outputs("sh_single", 16'h1234);
    check("sh_err", 32'(bus.access_error), 32'd0);

    // Timeout against a stuck RAM: write held exactly TIMEOUT cycles.
    set_flags(1'b0, 1'b0, 1'b1, 1'b0);
    bus.target_address = 16'h0042;
    bus.target_data    = 16'h0055;
    bus.ram_ready      = 1'b0;
    wr_cycles = 0;
    retire_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.ram_write === 1'b1) wr_cycles++;
      if (bus.reset_memory_access === 1'b1) begin
        retire_at = i;
        break;
      end
    end
    check("to_wr_cycles", 32'(wr_cycles), 32'd4);
    check("to_retire_at", 32'(retire_at), 32'd5);
    check("to_err",       32'(bus.access_error), 32'd1);
    check("to_mdata",     32'(bus.memory_data), 32'h1234);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    bus.ram_ready = 1'b1;
    check_idle_outputs("to_end", 16'h1234);
    tick();
    check("to_err_sticky", 32'(bus.access_error), 32'd1);

    // Reset clears the sticky error.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_err",   32'(bus.access_error), 32'd0);
    check("rst2_mdata", 32'(bus.memory_data), 32'h0000);

    // Conflicting flags: load_byte wins, error raised.
    set_flags(1'b1, 1'b0, 1'b1, 1'b0);
    bus.target_address = 16'h0200;
    bus.target_data    = 16'h0077;
    bus.ram_read_data  = 8'h5A;
    bus.ram_ready      = 1'b1;
    tick();
    check("cf_rd",     32'(bus.ram_read), 32'd1);
    check("cf_wr",     32'(bus.ram_write), 32'd0);
    check("cf_err",    32'(bus.access_error), 32'd1);
    tick();
    check("cf_retire", 32'(bus.reset_memory_access), 32'd1);
    check("cf_mdata",  32'(bus.memory_data), 32'h005A);
    tick();
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("cf_end", 16'h005A);

    // Reset during BEAT1 of a halfword load abandons it without a retire pulse.
    set_flags(1'b0, 1'b1, 1'b0, 1'b0);
    bus.target_address = 16'h0300;
    bus.ram_read_data  = 8'h11;
    tick();
    check("mr_b0_addr", 32'(bus.ram_address), 32'h0300);
    tick();
    check("mr_b1_addr", 32'(bus.ram_address), 32'h0301);
    check("mr_b1_rd",   32'(bus.ram_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_outputs("mr_after", 16'h0000);
    check("mr_err", 32'(bus.access_error), 32'd0);
    tick();
    check_idle_outputs("mr_after2", 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_responder.md
Name: memory_access_responder

Overview:
- Responder end of the load/store memory-access handshake.
- Accepts level-held request flags (load/store, byte/halfword) with target_address/target_data and services them over a byte-wide RAM port with wait states.
- Returns load results on memory_data and pulses reset_memory_access to retire the request.
- Sits between the load/store unit and the external byte RAM.

Parameters:
TIMEOUT, 255, maximum cycles to wait for ram_ready per byte beat before aborting (1..65535)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
memory_access_load_byte  input  1  level request: load 1 byte
memory_access_load_halfword  input  1  level request: load 2 bytes
memory_access_store_byte  input  1  level request: store 1 byte
memory_access_store_halfword  input  1  level request: store 2 bytes
target_address  input  16  byte address of access
target_data  input  16  store data (byte store uses [7:0])
memory_data  output  16  registered load result
reset_memory_access  output  1  one-cycle retire pulse to requester
busy  output  1  high in any state except IDLE
access_error  output  1  sticky: timeout or multiple simultaneous flags
ram_address  output  16  byte address to RAM
ram_read  output  1  read strobe, held until ram_ready
ram_write  output  1  write strobe, held until ram_ready
ram_write_data  output  8  write byte
ram_read_data  input  8  read byte, valid when ram_ready
ram_ready  input  1  beat complete (read data valid / write accepted)

Behaviour:
- Reset: state IDLE. memory_data=0, reset_memory_access=0, busy=0, access_error=0, ram_read=0, ram_write=0, ram_address=0, ram_write_data=0, internal counters/latches=0. Reset mid-access abandons it immediately, no retire pulse.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: if any flag high, latch op, target_address, target_data, go BEAT0.
  - Priority for multiple flags: load_byte > load_halfword > store_byte > store_halfword.
  - Multiple flags also set access_error.
- BEAT0: ram_address=addr. ram_read (loads) or ram_write (stores) high. ram_write_data=data[7:0].
  - On ram_ready: loads capture ram_read_data into low-byte holding register; strobes drop.
  - Halfword ops go to BEAT1; byte ops go to DONE.
- BEAT1: ram_address=addr+1, 16-bit wrap (0xFFFF -> 0x0000). ram_write_data=data[15:8].
  - On ram_ready: loads capture high byte; go DONE.
- DONE: reset_memory_access=1 for exactly this cycle; return to IDLE.
  - memory_data updates atomically on the transition into DONE:
    - load_byte: {8'h00, b0}
    - load_halfword: {b1, b0}, little-endian
    - stores: memory_data unchanged.
- Flag handshake: the requester clears its flags on the edge where reset_memory_access=1. IDLE re-samples flags only from the cycle after DONE, so a retired request is never re-serviced.
- Strobes are registered, never asserted in IDLE/DONE, and never both high.
- Timeout: per-beat wait counter resets on beat entry.
  - If TIMEOUT cycles elapse without ram_ready: drop strobes, set access_error, go DONE. memory_data is not updated; the retire pulse is still issued.
  - access_error is cleared only by reset.
- Latency with ram_ready tied high: flag seen in IDLE at cycle N -> retire pulse at N+2 (byte) or N+3 (halfword). Each ram wait cycle adds 1.
- Throughput: at most one access in flight. busy=1 from BEAT0 through DONE.

Test Plan:
1. Reset sequence:
   - stimulus: reset high 2 cycles while flags=0, ram_ready=1
   - required: every output 0 after the reset edge and afterwards.
2. Byte load, zero-extend:
   - stimulus: load_byte, addr=0x1234, ram returns 0xAB with ready=1
   - required: ram_read with ram_address=0x1234 for 1 cycle; reset_memory_access 2 cycles after request; memory_data=0x00AB.
3. Halfword load with 0xFFFF wrap:
   - stimulus: load_halfword, addr=0xFFFF, ram returns 0x34 then 0x12, 2 wait cycles on the first beat
   - required: addresses 0xFFFF then 0x0000; retire at N+5; memory_data=0x1234.
4. Halfword store:
   - stimulus: store_halfword, addr=0x0100, data=0xBEEF
   - required: writes 0xEF@0x0100 then 0xBE@0x0101; memory_data unchanged; exactly one retire pulse.
5. Timeout, stuck RAM:
   - stimulus: TIMEOUT=4, store_byte, ram_ready=0 forever
   - required: ram_write high for exactly 4 cycles; access_error=1 (sticky); retire pulse; memory_data unchanged.
6. Conflicting flags and mid-access reset:
   - stimulus: load_byte and store_byte high together
   - required: load serviced, access_error=1.
   - stimulus: reset asserted during BEAT1 of a halfword load
   - required: IDLE next cycle, no retire pulse, memory_data=0.
